arrow_scheduler: RTL

Shares the single arrow-animation resource between N skeleton shooters and sequences each shot through its flight/display window. A round-robin arbiter picks one shooter, and the block issues a one-cycle `who_shoot` strobe to the arrow animation. It then blocks new shots until the animation window has elapsed, applies a per-shooter cooldown, counts hits against Steve's lives and drives the game-level `alive` flag.

---
 rtl/arrow_pkg.sv | 26 ++
 rtl/arrow_scheduler_if.sv | 33 +++
 rtl/arrow_scheduler_rr_arbiter.sv | 36 +++
 rtl/arrow_scheduler.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/arrow_pkg.sv
// ============================================================================
//  arrow_pkg
//  Shared types and default constants for the arrow shot scheduler.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package arrow_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OVER  = 2'd3
  } sched_state_t;

  localparam logic [7:0] WHO_NONE = 8'd0;

  localparam int DEF_N_SHOOTERS  = 4;
  localparam int DEF_SHOT_WINDOW = 27000001;
  localparam int DEF_COOLDOWN    = 50000000;
  localparam int DEF_MAX_LIVES   = 3;

endpackage

`default_nettype wire

// File: rtl/arrow_scheduler_if.sv
// ============================================================================
//  arrow_scheduler_if
//  Shooter requests, game control and animation strobe bundle.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface arrow_scheduler_if
  import arrow_pkg::*;
#(
  parameter int N_SHOOTERS = DEF_N_SHOOTERS
);
  logic [N_SHOOTERS-1:0] req;
  logic                  restart;
  logic                  hit;
  logic [N_SHOOTERS-1:0] grant;
  logic [7:0]            who_shoot;
  logic                  busy;
  logic [2:0]            lives;
  logic                  alive;

  modport master (
    output req, restart, hit,
    input  grant, who_shoot, busy, lives, alive
  );

  modport slave (
    input  req, restart, hit,
    output grant, who_shoot, busy, lives, alive
  );
endinterface

`default_nettype wire

// File: rtl/arrow_scheduler_rr_arbiter.sv
// ============================================================================
//  rr_arbiter
//  Combinational round-robin pick: first eligible index at or after pointer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  wire logic [N-1:0]  i_eligible,
  input  wire logic [PW-1:0] i_ptr,
  output logic      [PW-1:0] o_winner,
  output logic               o_valid
);

  logic [PW-1:0] w_idx;

  // Scan offsets from far to near so the nearest eligible index wins.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = PW'((int'(i_ptr) + k) % N);
      if (i_eligible[w_idx]) begin
        o_winner = w_idx;
        o_valid  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/arrow_scheduler.sv
// ============================================================================
//  arrow_scheduler
//  Arbitrates shooters onto the arrow animation, times each shot, tracks lives.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module arrow_scheduler
  import arrow_pkg::*;
#(
  parameter int N_SHOOTERS  = DEF_N_SHOOTERS,
  parameter int SHOT_WINDOW = DEF_SHOT_WINDOW,
  parameter int COOLDOWN    = DEF_COOLDOWN,
  parameter int MAX_LIVES   = DEF_MAX_LIVES
) (
  input wire logic        Clk,
  input wire logic        Reset_n,
  arrow_scheduler_if.slave bus
);

  localparam int PW = (N_SHOOTERS > 1) ? $clog2(N_SHOOTERS) : 1;
  localparam int WW = $clog2(SHOT_WINDOW + 1);
  localparam int CW = $clog2(COOLDOWN + 1);

  localparam logic [WW-1:0]         c_win_load = WW'(SHOT_WINDOW - 1);
  localparam logic [CW-1:0]         c_cool_load = CW'(COOLDOWN);
  localparam logic [2:0]            c_lives_init = 3'(MAX_LIVES);
  localparam logic [N_SHOOTERS-1:0] c_one = N_SHOOTERS'(1);

  sched_state_t          r_state, w_state_nxt;
  logic [PW-1:0]         r_ptr, r_winner, w_pick;
  logic                  w_pick_vld;
  logic [N_SHOOTERS-1:0] w_cooling, w_eligible;
  logic [CW-1:0]         r_cool [N_SHOOTERS];
  logic [WW-1:0]         r_win_cnt;
  logic [2:0]            r_lives, w_lives_nxt;
  logic                  r_alive, r_hit_prev, r_hit_taken;
  logic                  w_hit_edge, w_hit_count;
  logic [N_SHOOTERS-1:0] r_grant;
  logic [7:0]            r_who;
  logic                  r_busy;

  for (genvar i = 0; i < N_SHOOTERS; i++) begin : g_cool
    assign w_cooling[i] = (r_cool[i] != '0);
  end

  assign w_eligible = bus.req & ~w_cooling;

  rr_arbiter #(
    .N  (N_SHOOTERS),
    .PW (PW)
  ) u_rr_arbiter (
    .i_eligible (w_eligible),
    .i_ptr      (r_ptr),
    .o_winner   (w_pick),
    .o_valid    (w_pick_vld)
  );

  // The taken flag is being cleared during ISSUE, so an edge there always counts.
  assign w_hit_edge  = bus.hit & ~r_hit_prev;
  assign w_hit_count = w_hit_edge &
                       ((r_state == S_ISSUE) | ((r_state == S_WAIT) & ~r_hit_taken));
  assign w_lives_nxt = (w_hit_count && (r_lives != 3'd0)) ? (r_lives - 3'd1) : r_lives;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_pick_vld) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (r_win_cnt == '0) w_state_nxt = (w_lives_nxt == 3'd0) ? S_OVER : S_IDLE;
      S_OVER:  w_state_nxt = S_OVER;
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.restart) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_winner    <= '0;
      r_win_cnt   <= '0;
      r_lives     <= c_lives_init;
      r_alive     <= 1'b1;
      r_hit_prev  <= 1'b0;
      r_hit_taken <= 1'b0;
      r_grant     <= '0;
      r_who       <= WHO_NONE;
      r_busy      <= 1'b0;
      for (int i = 0; i < N_SHOOTERS; i++) r_cool[i] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hit_prev <= bus.hit;
      if (bus.restart) begin
        r_ptr       <= '0;
        r_win_cnt   <= '0;
        r_lives     <= c_lives_init;
        r_alive     <= 1'b1;
        r_hit_taken <= 1'b0;
        r_grant     <= '0;
        r_who       <= WHO_NONE;
        r_busy      <= 1'b0;
        for (int i = 0; i < N_SHOOTERS; i++) r_cool[i] <= '0;
      end else begin
        if ((r_state == S_IDLE) && (w_state_nxt == S_ISSUE)) begin
          r_grant  <= c_one << w_pick;
          r_who    <= 8'(w_pick) + 8'd1;
          r_winner <= w_pick;
        end else begin
          r_grant <= '0;
          r_who   <= WHO_NONE;
        end
        r_busy <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_WAIT);

        for (int i = 0; i < N_SHOOTERS; i++) begin
          if ((r_state == S_ISSUE) && (r_winner == PW'(i))) r_cool[i] <= c_cool_load;
          else if (r_cool[i] != '0)                         r_cool[i] <= r_cool[i] - CW'(1);
        end

        if (r_state == S_ISSUE) begin
          r_win_cnt   <= c_win_load;
          r_ptr       <= (r_winner == PW'(N_SHOOTERS - 1)) ? '0 : (r_winner + PW'(1));
          r_hit_taken <= w_hit_count;
        end else begin
          if ((r_state == S_WAIT) && (r_win_cnt != '0)) r_win_cnt <= r_win_cnt - WW'(1);
          if (w_hit_count) r_hit_taken <= 1'b1;
        end

        r_lives <= w_lives_nxt;
        r_alive <= (w_lives_nxt != 3'd0);
      end
    end
  end

  assign bus.grant     = r_grant;
  assign bus.who_shoot = r_who;
  assign bus.busy      = r_busy;
  assign bus.lives     = r_lives;
  assign bus.alive     = r_alive;

endmodule

`default_nettype wire
